// File: rtl/mac_lane_accumulator.sv
// mac_lane_accumulator: sums a run of signed Q(IL).(FL) per-tile partial dot
// products f into a wide guarded accumulator. It then returns one saturated
// result over a valid/ready handshake.
// Optional feature macro: MAC_ACC_RELU_EN. When it is defined, a negative
// saturated result is clamped to zero before it is loaded into out_data.
module mac_lane_accumulator #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int CNT_W = 6,
    parameter int GUARD = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_tiles,
    input  logic                 in_valid,
    input  logic [IL+FL-1:0]     f,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IL+FL-1:0]     out_data,
    output logic                 busy,
    output logic                 overflow
);

    localparam int W  = IL + FL;
    localparam int AW = W + GUARD;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                state;
    logic signed [AW-1:0]  acc;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      ntiles;
    logic signed [AW-1:0]  f_ext;
    logic signed [AW-1:0]  acc_sum;

    // The sum no longer fits in W bits when the guard bits and the
    // result sign bit are not all copies of one another.
    function automatic logic ovf_of(input logic signed [AW-1:0] s);
        logic [GUARD:0] hi;
        hi = s[AW-1:W-1];
        return !((&hi) || !(|hi));
    endfunction

    // Clamp to the W-bit signed range. An in-range value keeps its low W bits exactly.
    function automatic logic signed [W-1:0] sat_of(input logic signed [AW-1:0] s);
        if (ovf_of(s))
            return s[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return s[W-1:0];
    endfunction

    // Optional rectification stage. It is applied after saturation, so overflow ignores it.
    function automatic logic signed [W-1:0] post_of(input logic signed [W-1:0] v);
`ifdef MAC_ACC_RELU_EN
        return v[W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Sign-extend the incoming partial sum and form the candidate accumulator value.
    always_comb begin
        f_ext   = {{GUARD{f[W-1]}}, f};
        acc_sum = acc + f_ext;
    end

    // Control FSM. All handshake and status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ntiles    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        ntiles   <= num_tiles;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (num_tiles == '0) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_sum;
                        cnt <= cnt + CNT_ONE;
                        if (cnt == ntiles - CNT_ONE) begin
                            out_data  <= post_of(sat_of(acc_sum));
                            overflow  <= ovf_of(acc_sum);
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_lane_accumulator.sv
// Bench for mac_lane_accumulator (IL=4, FL=16, CNT_W=6, GUARD=6).
// A reference model tracks each operation with plain integer sums. The model
// is checked against the DUT on every falling edge. Directed literal results
// pin the model, and randomized operations exercise the rest.
module tb_mac_lane_accumulator;

    localparam longint MAXP = (longint'(1) <<< 19) - 1;
    localparam longint MINN = -(longint'(1) <<< 19);

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  num_tiles;
    logic        in_valid;
    logic [19:0] f;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic        busy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] beats [64];

    mac_lane_accumulator #(.IL(4), .FL(16), .CNT_W(6), .GUARD(6)) dut (
        .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
        .in_valid(in_valid), .f(f), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result for a completed sum: clamp, then optionally rectify.
    function automatic logic [19:0] ref_data(input longint s);
        longint r;
        r = s;
        if (r > MAXP) r = MAXP;
        else if (r < MINN) r = MINN;
`ifdef MAC_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[19:0];
    endfunction

    function automatic logic ref_ovf(input longint s);
        return (s > MAXP) || (s < MINN);
    endfunction

    // Reference model: phase 0 idle, 1 collecting beats, 2 result offered.
    int          m_phase = 0;
    longint      m_sum   = 0;
    int          m_left  = 0;
    logic [19:0] m_out   = '0;
    logic        m_ovf   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_sum   <= 0;
            m_left  <= 0;
            m_out   <= '0;
            m_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sum <= 0;
                m_ovf <= 1'b0;
                if (num_tiles == 0) begin
                    m_out   <= '0;
                    m_phase <= 2;
                end else begin
                    m_left  <= int'(num_tiles);
                    m_phase <= 1;
                end
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_sum  <= m_sum + longint'($signed(f));
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_out   <= ref_data(m_sum + longint'($signed(f)));
                    m_ovf   <= ref_ovf(m_sum + longint'($signed(f)));
                    m_phase <= 2;
                end
            end
        end else begin
            if (out_ready) m_phase <= 0;
        end
    end

    // Compare the DUT with the model on every falling edge.
    always @(negedge clk) begin
        check("in_ready",  32'(in_ready),  32'(m_phase == 1));
        check("out_valid", 32'(out_valid), 32'(m_phase == 2));
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("out_data",  32'(out_data),  32'(m_out));
        check("overflow",  32'(overflow),  32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one complete operation from start to the accepted result.
    task automatic do_op(input int n, input int gap, input int hold, input bit pin,
                         input logic [19:0] lit_data, input logic lit_ovf);
        start     = 1'b1;
        num_tiles = 6'(n);
        in_valid  = 1'($urandom_range(0, 1));
        f         = 20'($urandom);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        if (n == 0) check("zero_tile_latency", 32'(out_valid), 32'h1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            f        = beats[i];
            tick();
            in_valid = 1'b0;
            f        = 20'($urandom);
            if (i == n - 1) begin
                check("last_beat_latency", 32'(out_valid), 32'h1);
            end else begin
                check("early_out_valid", 32'(out_valid), 32'h0);
                repeat (gap) tick();
            end
        end
        if (pin) begin
            check("lit_data", 32'(out_data), 32'(lit_data));
            check("lit_ovf",  32'(overflow), 32'(lit_ovf));
        end
        for (int h = 0; h < hold; h++) begin
            start     = 1'b1;
            num_tiles = 6'($urandom_range(0, 63));
            in_valid  = 1'($urandom_range(0, 1));
            tick();
            check("hold_in_ready", 32'(in_ready), 32'h0);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_tiles = '0; in_valid = 1'b0;
        f = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_out_data", 32'(out_data),  32'h0);
        check("rst_ovf",      32'(overflow),  32'h0);
        check("rst_in_ready", 32'(in_ready),  32'h0);
        reset = 1'b0;
        tick();

        // Basic three-tile sum.
        beats[0] = 20'h10000; beats[1] = 20'h20000; beats[2] = 20'hF8000;
        do_op(3, 0, 0, 1'b1, 20'h28000, 1'b0);

        // Positive and negative saturation.
        for (int i = 0; i < 4; i++) beats[i] = 20'h70000;
        do_op(4, 0, 0, 1'b1, 20'h7FFFF, 1'b1);
        beats[0] = 20'h80000; beats[1] = 20'h80000;
`ifdef MAC_ACC_RELU_EN
        do_op(2, 0, 0, 1'b1, 20'h00000, 1'b1);
`else
        do_op(2, 0, 0, 1'b1, 20'h80000, 1'b1);
`endif

        // Gaps between beats, then a long backpressure hold with start pulses.
        beats[0] = 20'h10000; beats[1] = 20'h10000;
        do_op(2, 3, 5, 1'b1, 20'h20000, 1'b0);

        // Reset mid-operation, coincident with start.
        start = 1'b1; num_tiles = 6'd4; tick(); start = 1'b0;
        in_valid = 1'b1; f = 20'h10000; tick(); tick(); in_valid = 1'b0;
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        check("midrst_busy",      32'(busy),      32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        tick(); tick();
        check("midrst_no_output", 32'(out_valid), 32'h0);
        beats[0] = 20'h04000;
        do_op(1, 0, 0, 1'b1, 20'h04000, 1'b0);

        // Zero tiles.
        do_op(0, 0, 1, 1'b1, 20'h00000, 1'b0);

        // Negative in-range result.
        beats[0] = 20'h10000; beats[1] = 20'hE8000;
`ifdef MAC_ACC_RELU_EN
        do_op(2, 0, 0, 1'b1, 20'h00000, 1'b0);
`else
        do_op(2, 0, 0, 1'b1, 20'hF8000, 1'b0);
`endif

        // Maximum tile count of full-scale beats, exercising the guard bits.
        for (int i = 0; i < 63; i++) beats[i] = 20'h7FFFF;
        do_op(63, 0, 0, 1'b1, 20'h7FFFF, 1'b1);

        // Randomized operations.
        for (int t = 0; t < 40; t++) begin
            int n;
            n = (t % 10 == 9) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                logic [19:0] r;
                r = 20'($urandom);
                beats[i] = ($urandom_range(0, 3) != 0) ? {{4{r[15]}}, r[15:0]} : r;
            end
            do_op(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
